// File: rtl/thermo32_expander_pkg.sv
// Shared types and helpers for the count-to-thermometer expander.
// Provides the stage record, sizing constants and the 3-bit partial decode.
package thermo_pkg;

  localparam int NBITS_DEF  = 32;
  localparam int CW_DEF     = 6;
  localparam int BYTE_W     = 8;
  localparam int NBYTES_MAX = NBITS_DEF / BYTE_W;

  typedef struct packed {
    logic              valid;
    logic [CW_DEF-1:0] count;
    logic              sat;
  } stage_t;

  // Ones in positions [n-1:0] of one byte.
  function automatic logic [BYTE_W-1:0] lo_therm(input logic [2:0] n);
    logic [BYTE_W-1:0] t;
    t = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      t[i] = (3'(i) < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/thermo32_expander_if.sv
// Valid/ready bundle between a count producer and the thermometer expander.
// The expander takes the slave view; the driving agent takes the master view.
interface thermo32_expander_if #(
  parameter int NBITS = thermo_pkg::NBITS_DEF,
  parameter int CW    = thermo_pkg::CW_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_count;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_word;
  logic             out_sat;
  logic             out_err;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_word, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_word, out_sat, out_err
  );
endinterface

// File: rtl/popcount_tree.sv
// Balanced pairwise adder-tree population count; compiled only with THERMO_CHECK_EN.
// N must be a power of two and W wide enough to hold N.
`ifdef THERMO_CHECK_EN
module popcount_tree #(
  parameter int N = 32,
  parameter int W = 6
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);
  localparam int LVLS = $clog2(N);

  logic [W-1:0] sum [LVLS+1][N];

  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int i = 0; i < N; i++) begin
        sum[l][i] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      sum[0][i] = W'(bits[i]);
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < (N >> (l + 1)); i++) begin
        sum[l+1][i] = sum[l][2*i] + sum[l][2*i+1];
      end
    end
  end

  assign count = sum[LVLS][0];
endmodule
`endif

// File: rtl/thermo8_dec.sv
// 3-bit count to 8-bit LSB-first thermometer, purely combinational.
module thermo8_dec
  import thermo_pkg::*;
(
  input  logic [2:0]        cnt,
  output logic [BYTE_W-1:0] therm
);
  assign therm = lo_therm(cnt);
endmodule

// File: rtl/thermo32_expander.sv
// Three-stage count-to-thermometer expander (clamp, byte decode, compose) with a global stall.
// Define THERMO_CHECK_EN to add a sticky popcount self-check on every emitted word (out_err).
module thermo32_expander
  import thermo_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int CW    = CW_DEF
) (
  input logic                clk,
  input logic                rst_n,
  thermo32_expander_if.slave bus
);

  logic advance;

  stage_t                s1_d, s1_q;
  logic [CW-1:0]         in_count_w;
  logic [CW_DEF-1:0]     in_cnt;

  logic                  s2_valid_q, s2_sat_q;
  logic [2:0]            s2_hi_d, s2_hi_q;
  logic [NBYTES_MAX-1:0] s2_full_d, s2_full_q;
  logic [BYTE_W-1:0]     s2_lo_d, s2_lo_q;

  logic [NBITS_DEF-1:0]  s3_word;
  logic                  out_valid_d, out_valid_q;
  logic [NBITS-1:0]      out_word_d, out_word_q;
  logic                  out_sat_d, out_sat_q;
  logic                  out_err_d, out_err_q;

  // A held output freezes the whole pipe; bubbles advance like real words.
  assign advance      = ~(out_valid_q & ~bus.out_ready);
  assign bus.in_ready = advance;
  assign in_count_w   = bus.in_count;

  // S1: clamp oversize counts to NBITS and flag the saturation.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    s1_d       = '0;
    in_cnt     = CW_DEF'(in_count_w);
    s1_d.valid = bus.in_valid;
    if (bus.in_valid) begin
      if (in_cnt > CW_DEF'(NBITS)) begin
        s1_d.count = CW_DEF'(NBITS);
        s1_d.sat   = 1'b1;
      end else begin
        s1_d.count = in_cnt;
      end
    end
  end

  // S2: hi selects how many bytes are full, lo is the partial byte; 32 gives hi=4, lo=0.
  thermo8_dec u_lo_dec (
    .cnt   (s1_q.count[2:0]),
    .therm (s2_lo_d)
  );

  always_comb begin
    s2_hi_d   = s1_q.count[CW_DEF-1:3];
    s2_full_d = '0;
    for (int k = 0; k < NBYTES_MAX; k++) begin
      s2_full_d[k] = (3'(k) < s2_hi_d);
    end
  end

  // S3: full bytes are FF, byte hi takes the partial, the rest stay zero.
  always_comb begin
    s3_word = '0;
    for (int k = 0; k < NBYTES_MAX; k++) begin
      if (s2_full_q[k]) begin
        s3_word[k*BYTE_W +: BYTE_W] = '1;
      end else if (3'(k) == s2_hi_q) begin
        s3_word[k*BYTE_W +: BYTE_W] = s2_lo_q;
      end
    end
  end

  always_comb begin
    out_valid_d = s2_valid_q;
    out_word_d  = s3_word[NBITS-1:0];
    out_sat_d   = s2_sat_q;
  end

`ifdef THERMO_CHECK_EN
  logic [CW_DEF-1:0] s2_count_q;
  logic [CW_DEF-1:0] pop_cnt;

  popcount_tree #(.N(NBITS_DEF), .W(CW_DEF)) u_pop (
    .bits  (s3_word),
    .count (pop_cnt)
  );

  // Bubbles never raise the flag; once set it stays until reset.
  always_comb begin
    out_err_d = out_err_q | (s2_valid_q & (pop_cnt != s2_count_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_count_q <= '0;
    end else if (advance) begin
      s2_count_q <= s1_q.count;
    end
  end
`else
  always_comb begin
    out_err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset along with the valid bits so out_word reads 0 after reset.
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_sat_q    <= 1'b0;
      s2_hi_q     <= '0;
      s2_full_q   <= '0;
      s2_lo_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_sat_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
      s1_q        <= s1_d;
      s2_valid_q  <= s1_q.valid;
      s2_sat_q    <= s1_q.sat;
      s2_hi_q     <= s2_hi_d;
      s2_full_q   <= s2_full_d;
      s2_lo_q     <= s2_lo_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_sat_q   <= out_sat_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_thermo32_expander.sv
// Self-checking bench for thermo32_expander: vector table plus stall, sparse, reset and error sequences.
// Expected words are pushed to a scoreboard at accept time and popped when the DUT emits.
module tb_thermo32_expander;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  thermo32_expander_if bus ();

  thermo32_expander dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  count;
    logic [31:0] word;
    logic        sat;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        sat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[14];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic lat_strict = 1'b0;
  logic err_exp    = 1'b0;
  logic stall_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 64'(bus.out_word), 64'hDEAD);
      end else begin
        mon_e = sb.pop_front();
        check("out_word", 64'(bus.out_word), 64'(mon_e.word));
        check("out_sat", 64'(bus.out_sat), 64'(mon_e.sat));
        check("out_err", 64'(bus.out_err), 64'(err_exp));
        if (lat_strict) check("latency", 64'(cyc - mon_e.acc_cyc), 64'd3);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the count.
  task automatic send(input logic [5:0] c, input logic [31:0] w, input logic s);
    bus.in_valid = 1'b1;
    bus.in_count = c;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (t >= 50) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    sb.push_back('{word: w, sat: s, acc_cyc: cyc});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{6'd0,  32'h0000_0000, 1'b0};
    vecs[1]  = '{6'd1,  32'h0000_0001, 1'b0};
    vecs[2]  = '{6'd8,  32'h0000_00FF, 1'b0};
    vecs[3]  = '{6'd31, 32'h7FFF_FFFF, 1'b0};
    vecs[4]  = '{6'd32, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{6'd45, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{6'd63, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{6'd33, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{6'd7,  32'h0000_007F, 1'b0};
    vecs[9]  = '{6'd9,  32'h0000_01FF, 1'b0};
    vecs[10] = '{6'd16, 32'h0000_FFFF, 1'b0};
    vecs[11] = '{6'd24, 32'h00FF_FFFF, 1'b0};
    vecs[12] = '{6'd25, 32'h01FF_FFFF, 1'b0};
    vecs[13] = '{6'd2,  32'h0000_0003, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_count  = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_word", 64'(bus.out_word), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;

    // Back-to-back table with exact 3-cycle latency.
    lat_strict = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].count, vecs[i].word, vecs[i].sat);
    end
    drain();

    // Stall while 0x1F is presented: word frozen, input blocked, order kept.
    lat_strict = 1'b0;
    stall_seen = 1'b0;
    fork
      begin
        send(6'd5,  32'h0000_001F, 1'b0);
        send(6'd9,  32'h0000_01FF, 1'b0);
        send(6'd17, 32'h0001_FFFF, 1'b0);
        send(6'd2,  32'h0000_0003, 1'b0);
      end
      begin
        for (int t = 0; t < 50; t++) begin
          @(posedge clk);
          #1;
          if (bus.out_valid && bus.out_word == 32'h0000_001F) begin
            stall_seen = 1'b1;
            break;
          end
        end
        check("stall_trigger", 64'(stall_seen), 64'd1);
        if (stall_seen) begin
          bus.out_ready = 1'b0;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_word", 64'(bus.out_word), 64'h1F);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          end
          @(posedge clk);
          #1;
          bus.out_ready = 1'b1;
        end
      end
    join
    drain();

    // Sparse input: one count every three cycles.
    lat_strict = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(6'd12, 32'h0000_0FFF, 1'b0);
      idle(2);
    end
    drain();

    // Reset with three words in flight: nothing stale may emerge.
    send(6'd3, 32'h0000_0007, 1'b0);
    send(6'd4, 32'h0000_000F, 1'b0);
    send(6'd6, 32'h0000_003F, 1'b0);
    check("inflight_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_word", 64'(bus.out_word), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_stale_valid", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Pipeline still works after the mid-run reset.
    send(6'd20, 32'h000F_FFFF, 1'b0);
    drain();

`ifdef THERMO_CHECK_EN
    // Corrupt byte 3 bit 0 of the composed word: the checker must flag it and hold the flag.
    lat_strict = 1'b0;
    force dut.s3_word = 32'h0100_001F;
    err_exp = 1'b1;
    send(6'd5, 32'h0100_001F, 1'b0);
    drain();
    release dut.s3_word;
    send(6'd5, 32'h0000_001F, 1'b0);
    drain();
    idle(3);
`endif

    check("final_out_err", 64'(bus.out_err), 64'(err_exp));
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
